// File: rtl/regfile_dump.sv
// regfile_dump: walks registers 0..NUM_REGS-1 through one regfile read port
// and streams them out as indexed beats on a valid/ready interface.
// Optional feature macro: REGFILE_DUMP_CKSUM_EN appends one XOR-checksum beat
// (out_idx=0, out_last=1) after the final register beat.

module regfile_dump #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // Index of the final register beat; the counter stops here and never wraps.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CKSUM_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
      FIN  = 3'd3,
      CKLD = 3'd4
   } state_t;

   // Running XOR of every register word captured during the current dump.
   logic [DATA_W-1:0] cksum;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      FIN  = 2'd3
   } state_t;
`endif

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              hs;

   // Beat accepted by the sink at this edge.
   assign hs = out_valid && out_ready;

   // Dump sequencer: state, index counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
         cksum     <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               rd_addr <= '0;
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
                  cksum <= '0;
`endif
               end
            end

            LOAD: begin
               // rd_addr already equals cnt, so rd_data is this beat's word
               out_data  <= rd_data;
               out_idx   <= cnt;
               out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
               out_last  <= 1'b0;
               cksum     <= cksum ^ rd_data;
`else
               out_last  <= (cnt == LAST_IDX);
`endif
               state     <= SEND;
            end

            SEND: begin
               if (hs) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     out_last <= 1'b0;
                     done     <= 1'b1;
                     state    <= FIN;
                  end
`ifdef REGFILE_DUMP_CKSUM_EN
                  else if (cnt == LAST_IDX) begin
                     state <= CKLD;
                  end
`endif
                  else begin
                     cnt     <= cnt + ADDR_W'(1);
                     rd_addr <= cnt + ADDR_W'(1);
                     state   <= LOAD;
                  end
               end
            end

`ifdef REGFILE_DUMP_CKSUM_EN
            CKLD: begin
               // checksum beat takes the place of a register load
               out_data  <= cksum;
               out_idx   <= '0;
               out_last  <= 1'b1;
               out_valid <= 1'b1;
               state     <= SEND;
            end
`endif

            FIN: begin
               busy    <= 1'b0;
               cnt     <= '0;
               rd_addr <= '0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed, table-driven checks of regfile_dump with a
// behavioural 8x32 regfile attached to its read port.

module tb_regfile_dump;

   localparam int unsigned NUM_REGS = 8;
`ifdef REGFILE_DUMP_CKSUM_EN
   localparam int unsigned NB = NUM_REGS + 1;
`else
   localparam int unsigned NB = NUM_REGS;
`endif

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   logic        we;
   logic [2:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] regs [8] = '{default: 32'h0};

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   beat_t exp_tab [NB];

   regfile_dump #(.ADDR_W(3), .DATA_W(32), .NUM_REGS(NUM_REGS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // regfile model: combinational read, write on posedge
   assign rd_data = regs[rd_addr];
   always @(posedge clk) begin
      if (we) regs[waddr] <= wdata;
   end

   // cycle, handshake and done counters
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "/out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/out_data"},  out_data,       32'd0);
      chk({tag, "/out_idx"},   32'(out_idx),   32'd0);
      chk({tag, "/out_last"},  32'(out_last),  32'd0);
      chk({tag, "/busy"},      32'(busy),      32'd0);
      chk({tag, "/done"},      32'(done),      32'd0);
      chk({tag, "/rd_addr"},   32'(rd_addr),   32'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
   endtask

   // One dump; optional 5-cycle stall, mid-dump start, reset abort, concurrent writes.
   task automatic dump(input string tag, input int stall_beat, input int start_beat,
                       input int abort_beat, input bit cwrite);
      int d0, h0, c0, k;
      d0 = done_cnt;
      h0 = hs_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c0 = cyc;
      chk({tag, "/load_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < int'(NB); i++) begin
         if (i < int'(NUM_REGS))
            chk($sformatf("%s/rd_addr[%0d]", tag, i), 32'(rd_addr), 32'(i));
         chk($sformatf("%s/load_valid[%0d]", tag, i), 32'(out_valid), 32'd0);
         if (cwrite && i == 5) begin
            we = 1'b1; waddr = 3'd5; wdata = 32'h1234_5678;
         end
         if (cwrite && i == 3) begin
            we = 1'b1; waddr = 3'd2; wdata = 32'hFFFF_FFFF;
         end
         if (i == stall_beat) out_ready = 1'b0;
         k = 0;
         while (!out_valid && k < 4) begin
            @(negedge clk);
            we = 1'b0;
            k++;
         end
         we = 1'b0;
         chk($sformatf("%s/valid[%0d]", tag, i), 32'(out_valid), 32'd1);
         if (i == start_beat) start = 1'b1;
         if (i == abort_beat) begin
            rst_n = 1'b0;
            #1;
            check_zero({tag, "/async_rst"});
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk({tag, "/post_rst_busy"}, 32'(busy), 32'd0);
               chk({tag, "/post_rst_done"}, 32'(done), 32'd0);
            end
            chk({tag, "/no_done"}, 32'(done_cnt - d0), 32'd0);
            return;
         end
         if (i == stall_beat) begin
            repeat (5) begin
               chk($sformatf("%s/stall_valid[%0d]", tag, i), 32'(out_valid), 32'd1);
               chk($sformatf("%s/stall_idx[%0d]", tag, i), 32'(out_idx), 32'(exp_tab[i].idx));
               chk($sformatf("%s/stall_data[%0d]", tag, i), out_data, exp_tab[i].data);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
         chk($sformatf("%s/idx[%0d]", tag, i), 32'(out_idx), 32'(exp_tab[i].idx));
         chk($sformatf("%s/data[%0d]", tag, i), out_data, exp_tab[i].data);
         chk($sformatf("%s/last[%0d]", tag, i), 32'(out_last), 32'(exp_tab[i].last));
         @(negedge clk);
         start = 1'b0;
      end
      // FIN cycle
      chk({tag, "/fin_done"},  32'(done),      32'd1);
      chk({tag, "/fin_busy"},  32'(busy),      32'd1);
      chk({tag, "/fin_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/cycles"}, 32'(cyc - c0), 32'(2 * int'(NB) + ((stall_beat >= 0) ? 5 : 0)));
      @(negedge clk);
      chk({tag, "/idle_done"}, 32'(done), 32'd0);
      chk({tag, "/idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "/done_cnt"},  32'(done_cnt - d0), 32'd1);
      chk({tag, "/beats"},     32'(hs_cnt - h0), 32'(NB));
      if (start_beat >= 0) begin
         repeat (3) begin
            @(negedge clk);
            chk({tag, "/stay_idle_busy"},  32'(busy),      32'd0);
            chk({tag, "/stay_idle_valid"}, 32'(out_valid), 32'd0);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         exp_tab[i].idx  = 3'(i);
         exp_tab[i].data = 32'h0;
         exp_tab[i].last = (i == int'(NUM_REGS) - 1);
      end
      exp_tab[0].data = 32'hABCD_ABCD;
      exp_tab[1].data = 32'hDEAD_BEEF;
`ifdef REGFILE_DUMP_CKSUM_EN
      exp_tab[NUM_REGS-1].last = 1'b0;
      exp_tab[NUM_REGS].idx    = 3'd0;
      exp_tab[NUM_REGS].data   = 32'h7560_1522;
      exp_tab[NUM_REGS].last   = 1'b1;
`endif

      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      we        = 1'b0;
      waddr     = 3'd0;
      wdata     = 32'h0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      wr(3'd0, 32'hABCD_ABCD);
      wr(3'd1, 32'hDEAD_BEEF);
      chk("idle_before_start", 32'(busy), 32'd0);

      dump("full",       -1, -1, -1, 1'b0);
      dump("backpress",   1, -1, -1, 1'b0);
      dump("start_busy", -1,  3, -1, 1'b0);
      dump("abort",      -1, -1,  3, 1'b0);
      dump("fresh",      -1, -1, -1, 1'b0);
      dump("cwrite",     -1, -1, -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
